// File: rtl/mux8_pkg.sv
// Shared types and constants for the 8-source round-robin scheduler.
package mux8_pkg;
  localparam int NUM_SRC = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_pick8.sv
// Round-robin picker: first set request starting at ptr, wrapping mod 8.
module rr_pick8
  import mux8_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               any
);

  // Scan from the farthest offset down so the closest request to ptr wins last.
  always_comb begin
    winner = '0;
    any    = |req;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[ptr + SEL_W'(i)]) winner = ptr + SEL_W'(i);
    end
  end

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin burst scheduler driving the select of a shared 8:1 data mux.
module mux8_rr_scheduler
  import mux8_pkg::*;
#(
  parameter int DW        = 1,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SRC-1:0]    req,
  input  logic [NUM_SRC*DW-1:0] data_in,
  output logic [NUM_SRC-1:0]    gnt,
  output logic [SEL_W-1:0]      sel,
  output logic [DW-1:0]         out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  // Last burst index before forced release; unused when bursts are unlimited.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
  localparam bit               LIMITED  = (MAX_BURST != 0);

  state_t             state, state_n;
  logic [SEL_W-1:0]   ptr, ptr_n, sel_n, winner;
  logic [NUM_SRC-1:0] gnt_n;
  logic [CNT_W-1:0]   burst_cnt, burst_cnt_n;
  logic               any, xfer;

  logic [NUM_SRC-1:0][DW-1:0] words;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  // Shared datapath: the registered select steers one word to the consumer.
  assign words    = data_in;
  assign out_data = words[sel];

  // Valid is masked during reset so nothing can be accepted in the abort cycle.
  assign busy      = (state == GRANT);
  assign out_valid = busy && req[sel] && !rst;
  assign xfer      = busy && req[sel] && out_ready;

  // Next-state: grant the picked source from IDLE, release on drop or burst end.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    sel_n       = sel;
    gnt_n       = gnt;
    burst_cnt_n = burst_cnt;
    case (state)
      IDLE: begin
        if (any) begin
          state_n     = GRANT;
          sel_n       = winner;
          gnt_n       = NUM_SRC'(1) << winner;
          burst_cnt_n = '0;
        end
      end
      GRANT: begin
        if (!req[sel] || (xfer && LIMITED && burst_cnt == LAST_CNT)) begin
          state_n     = IDLE;
          gnt_n       = '0;
          ptr_n       = sel + SEL_W'(1);
          burst_cnt_n = '0;
        end else if (xfer) begin
          burst_cnt_n = burst_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      gnt       <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      sel       <= sel_n;
      gnt       <= gnt_n;
      burst_cnt <= burst_cnt_n;
    end
  end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Bench for mux8_rr_scheduler: cycle table plus hand sequences, transfers scoreboarded.
module tb_mux8_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] data_in;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic [0:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int ntests = 0;
  int nfail  = 0;

  typedef struct {
    logic [7:0] req;
    logic [7:0] din;
    logic       rdy;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       ov;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [2:0] sel;
    logic       data;
  } xfer_t;

  vec_t  tbl[$];
  xfer_t sb[$];

  mux8_rr_scheduler #(.DW(1), .MAX_BURST(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .gnt       (gnt),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic add(input logic [7:0] r, input logic [7:0] d, input logic rd,
                     input logic [7:0] g, input logic [2:0] s, input logic v, input logic b);
    vec_t t;
    t.req = r; t.din = d; t.rdy = rd; t.gnt = g; t.sel = s; t.ov = v; t.busy = b;
    tbl.push_back(t);
  endtask

  task automatic push_x(input logic [2:0] s, input logic d);
    xfer_t x;
    x.sel = s; x.data = d;
    sb.push_back(x);
  endtask

  // Scoreboard monitor: every accepted word must match the oldest expected one.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL unexpected_xfer: got sel=%0d with no expected transfer", sel);
        end else begin
          xfer_t e;
          e = sb.pop_front();
          chk("xfer_sel", 32'(sel), 32'(e.sel));
          chk("xfer_data", 32'(out_data), 32'(e.data));
        end
      end
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("valid_implies_gnt", 32'(!out_valid || gnt[sel]), 32'd1);
    end
  end

  initial begin
    rst = 1'b1; req = '0; data_in = '0; out_ready = 1'b0;
    step(); step();
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    step();
    rst = 1'b0;

    // Idle with no requests.
    for (int i = 0; i < 5; i++) add(8'h00, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    // Single source 3: four transfers, release, one bubble, regrant, drop.
    add(8'h08, 8'h08, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    add(8'h08, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b1);
    add(8'h08, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b1);
    add(8'h08, 8'h00, 1'b1, 8'h08, 3'd3, 1'b1, 1'b1);
    add(8'h08, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b1);
    add(8'h08, 8'h08, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0);
    add(8'h08, 8'h00, 1'b1, 8'h08, 3'd3, 1'b1, 1'b1);
    add(8'h00, 8'h08, 1'b1, 8'h08, 3'd3, 1'b0, 1'b1);
    add(8'h00, 8'h08, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0);
    // Backpressure on source 5: six stalled cycles, then four transfers.
    add(8'h20, 8'h20, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) add(8'h20, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b1);
    add(8'h20, 8'h20, 1'b1, 8'h20, 3'd5, 1'b1, 1'b1);
    add(8'h20, 8'h00, 1'b1, 8'h20, 3'd5, 1'b1, 1'b1);
    add(8'h20, 8'h20, 1'b1, 8'h20, 3'd5, 1'b1, 1'b1);
    add(8'h20, 8'h20, 1'b1, 8'h20, 3'd5, 1'b1, 1'b1);
    add(8'h00, 8'h20, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      req = tbl[i].req; data_in = tbl[i].din; out_ready = tbl[i].rdy;
      #2;
      chk($sformatf("row%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("row%0d_sel", i), 32'(sel), 32'(tbl[i].sel));
      chk($sformatf("row%0d_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      if (tbl[i].ov && tbl[i].rdy) push_x(tbl[i].sel, tbl[i].din[tbl[i].sel]);
      step();
    end

    // Round-robin wrap: all requesting, order 0..7 then 0 again.
    do_reset();
    req = 8'hFF; data_in = 8'hA5; out_ready = 1'b1;
    for (int g = 0; g < 9; g++) begin
      logic [2:0] e;
      e = 3'(g % 8);
      #2;
      chk($sformatf("rr%0d_gap_busy", g), 32'(busy), 32'h0);
      step();
      for (int k = 0; k < 4; k++) begin
        #2;
        chk($sformatf("rr%0d_gnt", g), 32'(gnt), 32'(8'h01 << e));
        chk($sformatf("rr%0d_sel", g), 32'(sel), 32'(e));
        push_x(e, data_in[e]);
        step();
      end
    end
    req = 8'h00;
    step();

    // Early drop: source 2 drops with ready high; pointer moves to 3 so 6 beats 1.
    do_reset();
    req = 8'h44; data_in = 8'h04; out_ready = 1'b1;
    #2; chk("drop_idle_gnt", 32'(gnt), 32'h0);
    step();
    #2;
    chk("drop_gnt2", 32'(gnt), 32'h04);
    chk("drop_sel2", 32'(sel), 32'd2);
    push_x(3'd2, 1'b1);
    step();
    req = 8'h42;
    #2;
    chk("drop_no_valid", 32'(out_valid), 32'h0);
    chk("drop_still_gnt", 32'(gnt), 32'h04);
    step();
    #2;
    chk("drop_released", 32'(gnt), 32'h0);
    chk("drop_busy", 32'(busy), 32'h0);
    step();
    req = 8'h00;
    #2;
    chk("drop_next_gnt6", 32'(gnt), 32'h40);
    chk("drop_next_sel6", 32'(sel), 32'd6);
    step(); step();

    // Reset mid-burst: source 4 after two transfers, then source 0 wins after reset.
    do_reset();
    req = 8'h10; data_in = 8'h10; out_ready = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      #2;
      chk("mid_gnt4", 32'(gnt), 32'h10);
      push_x(3'd4, 1'b1);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0; req = 8'h11; data_in = 8'h10;
    #2;
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_sel", 32'(sel), 32'h0);
    step();
    #2;
    chk("mid_after_gnt0", 32'(gnt), 32'h01);
    chk("mid_after_sel0", 32'(sel), 32'd0);
    push_x(3'd0, 1'b0);
    step();
    req = 8'h00;
    step(); step();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
